uart_echo_bridge: RTL and testbench
===================================

Name: uart_echo_bridge

Overview:
- Buffered byte bridge between the uart_rx and uart_tx instances in the UART test top.
- Each byte received (RX_DONE/RX_DATA) is pushed into a parametrised FIFO. A three-state TX controller drains the FIFO into uart_tx over the SEND/READY handshake.
- Also provides a last-received-byte register for the LEDs, a sticky overrun flag, and an echo-enable mode input.

Parameters:
- DATA_W, 8, byte width of RX/TX data and of the FIFO entries.
- FIFO_DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count.
- LAST_RESET, 8'hFF, reset value of LAST_BYTE.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RX_DONE  in  1  one-cycle strobe from uart_rx: RX_DATA is valid.
- RX_DATA  in  DATA_W  received byte.
- TX_READY  in  1  from uart_tx; high while the transmitter is idle.
- TX_SEND  out  1  request to uart_tx; held high until accepted.
- TX_DATA  out  DATA_W  byte presented to uart_tx; stable while TX_SEND is high and in WAIT.
- ECHO_EN  in  1  1 = drain the FIFO to TX; 0 = hold bytes in the FIFO.
- CLR_OVR  in  1  one-cycle clear of OVERRUN.
- LAST_BYTE  out  DATA_W  most recent received byte (drives the LEDs).
- OVERRUN  out  1  sticky flag: a byte was dropped because the FIFO was full.
- COUNT  out  CNT_W  FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (synchronous, active-high; one clock; RESET is the only reset):
  - TX_SEND=0, TX_DATA=0, LAST_BYTE=LAST_RESET, OVERRUN=0, COUNT=0.
  - FIFO pointers zeroed and TX FSM forced to IDLE.
  - Reset during SEND or WAIT abandons the byte in flight; no completion is tracked.
- RX side:
  - On RX_DONE, LAST_BYTE<=RX_DATA on the next edge, even when the byte is dropped.
  - Push when RX_DONE=1 and the FIFO is not full.
  - Push while full and with no pop in the same cycle: byte dropped, OVERRUN<=1.
  - Full plus simultaneous pop and push: both succeed, COUNT unchanged, no overrun.
- OVERRUN:
  - Cleared by CLR_OVR.
  - CLR_OVR and a new overrun in the same cycle: the set wins.
- FIFO:
  - Circular buffer, pointers wrap modulo FIFO_DEPTH.
  - Combinational read of the head entry.
  - COUNT is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
- TX FSM, states IDLE / SEND / WAIT:
  - IDLE:
    - Pop when ECHO_EN=1, COUNT!=0 and TX_READY=1: TX_DATA<=head, pop, TX_SEND<=1, go to SEND.
    - Otherwise stay in IDLE with TX_SEND=0.
  - SEND:
    - Hold TX_SEND=1 and TX_DATA until TX_READY=0, which means uart_tx accepted the byte.
    - Then TX_SEND<=0 and go to WAIT.
  - WAIT:
    - Hold TX_SEND=0; when TX_READY=1, go to IDLE.
- Timing:
  - Latency from RX_DONE to TX_SEND rising, FIFO empty and TX idle: 2 cycles (push edge, then IDLE pop edge).
  - Back-to-back bytes: minimum one IDLE cycle between a WAIT exit and the next SEND.
- ECHO_EN:
  - ECHO_EN=0 only blocks the IDLE->SEND transition.
  - A transfer already in SEND or WAIT always completes.
- Pop happens only in IDLE, so underflow is impossible; verify this with an assertion.
- X hygiene: with RX_DONE=0, RX_DATA is ignored.

Decomposition:
- Shared package uart_pkg:
  - TX FSM state encodings TX_IDLE=2'b00, TX_SEND=2'b01, TX_WAIT=2'b10.
  - Default byte width constant.
- Sub-module sync_fifo (params DATA_W, FIFO_DEPTH):
  - Ports: CLK, RESET, PUSH, PUSH_DATA, POP, HEAD, FULL, EMPTY, COUNT.
- Top-level rewiring:
  - The UART test top instantiates uart_echo_bridge between uart_rx and uart_tx.
  - LAST_BYTE drives the led output.

Test Plan:
- Reset, then a single RX_DONE with RX_DATA=8'hA5, ECHO_EN=1, TX_READY=1 -> LAST_BYTE=A5. TX_SEND rises 2 cycles after the strobe with TX_DATA=A5. After the model drops TX_READY, TX_SEND falls. COUNT returns to 0.
- Three strobes (8'h01, 8'h02, 8'h03) one cycle apart, with a uart_tx model that is busy 10 cycles per byte -> TX_DATA sequence is 01, 02, 03 in order. COUNT peaks at 2 or 3 and returns to 0. No OVERRUN.
- ECHO_EN=0 with 17 strobes of 8'h10..8'h20, FIFO_DEPTH=16 -> COUNT=16, OVERRUN=1, LAST_BYTE=20, TX_SEND stays 0. Then set ECHO_EN=1 -> 16 bytes 10..1F sent, 20 is never sent.
- FIFO full with the FSM in IDLE popping in the same cycle as an RX_DONE (8'h77) -> COUNT stays 16, OVERRUN stays 0, 77 appears as the last transmitted byte.
- OVERRUN=1, then CLR_OVR pulse -> OVERRUN=0. CLR_OVR pulse coincident with a full-FIFO drop -> OVERRUN=1.
- RESET asserted for one cycle while in SEND with TX_DATA=8'h5A -> next cycle TX_SEND=0, COUNT=0, LAST_BYTE=FF, FSM in IDLE. A later byte 8'h3C is sent normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART test top: default byte width and the
// state encodings of the echo bridge transmit controller.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE = 2'b00,
        TX_SEND = 2'b01,
        TX_WAIT = 2'b10
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with combinational head read and a registered
// occupancy count. A push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle; a pop from an empty FIFO is ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = BYTE_W,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PUSH,
    input  logic [DATA_W-1:0] PUSH_DATA,
    input  logic              POP,
    output logic [DATA_W-1:0] HEAD,
    output logic              FULL,
    output logic              EMPTY,
    output logic [CNT_W-1:0]  COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_r;
    logic              do_push;
    logic              do_pop;

    assign EMPTY   = (count_r == '0);
    assign FULL    = (count_r == CNT_W'(FIFO_DEPTH));
    assign do_pop  = POP && !EMPTY;
    assign do_push = PUSH && (!FULL || do_pop);
    assign HEAD    = mem[rd_ptr];
    assign COUNT   = count_r;

    // Entry storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= PUSH_DATA;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks net change.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_bridge.sv
// Buffered bridge between uart_rx and uart_tx. Received bytes are queued in
// a FIFO and, while echo is enabled, drained one at a time into uart_tx over
// the SEND/READY handshake. Also keeps the last received byte for the LEDs
// and a sticky overrun flag for bytes dropped on a full FIFO.
module uart_echo_bridge
    import uart_pkg::*;
#(
    parameter int                DATA_W     = BYTE_W,
    parameter int                FIFO_DEPTH = 16,
    parameter int                CNT_W      = $clog2(FIFO_DEPTH) + 1,
    parameter logic [DATA_W-1:0] LAST_RESET = DATA_W'(8'hFF)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RX_DONE,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              TX_READY,
    output logic              TX_SEND,
    output logic [DATA_W-1:0] TX_DATA,
    input  logic              ECHO_EN,
    input  logic              CLR_OVR,
    output logic [DATA_W-1:0] LAST_BYTE,
    output logic              OVERRUN,
    output logic [CNT_W-1:0]  COUNT
);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              send_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              overrun_set;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .PUSH      (RX_DONE),
        .PUSH_DATA (RX_DATA),
        .POP       (fifo_pop),
        .HEAD      (fifo_head),
        .FULL      (fifo_full),
        .EMPTY     (fifo_empty),
        .COUNT     (COUNT)
    );

    // A byte is lost only when it arrives on a full FIFO with no pop to make room.
    assign overrun_set = RX_DONE && fifo_full && !fifo_pop;

    // Last received byte follows every strobe, including dropped bytes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LAST_BYTE <= LAST_RESET;
        end else if (RX_DONE) begin
            LAST_BYTE <= RX_DATA;
        end
    end

    // Sticky overrun; a new drop takes priority over a coincident clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OVERRUN <= 1'b0;
        end else if (overrun_set) begin
            OVERRUN <= 1'b1;
        end else if (CLR_OVR) begin
            OVERRUN <= 1'b0;
        end
    end

    // TX controller state and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= uart_pkg::TX_IDLE;
            TX_SEND <= 1'b0;
            TX_DATA <= '0;
        end else begin
            state   <= state_nxt;
            TX_SEND <= send_nxt;
            TX_DATA <= data_nxt;
        end
    end

    // TX controller next state: pop only from IDLE, hold the byte until accepted.
    always_comb begin
        state_nxt = state;
        send_nxt  = TX_SEND;
        data_nxt  = TX_DATA;
        fifo_pop  = 1'b0;
        case (state)
            uart_pkg::TX_IDLE: begin
                send_nxt = 1'b0;
                if (ECHO_EN && !fifo_empty && TX_READY) begin
                    fifo_pop  = 1'b1;
                    data_nxt  = fifo_head;
                    send_nxt  = 1'b1;
                    state_nxt = uart_pkg::TX_SEND;
                end
            end
            uart_pkg::TX_SEND: begin
                send_nxt = 1'b1;
                if (!TX_READY) begin
                    send_nxt  = 1'b0;
                    state_nxt = uart_pkg::TX_WAIT;
                end
            end
            uart_pkg::TX_WAIT: begin
                send_nxt = 1'b0;
                if (TX_READY) begin
                    state_nxt = uart_pkg::TX_IDLE;
                end
            end
            default: begin
                send_nxt  = 1'b0;
                state_nxt = uart_pkg::TX_IDLE;
            end
        endcase
    end

    // Pops are issued only from IDLE with a non-empty FIFO, so underflow cannot occur.
    no_underflow: assert property (@(posedge CLK) disable iff (RESET) fifo_pop |-> !fifo_empty);

endmodule

// File: tb/tb_uart_echo_bridge.sv
// Directed testbench for uart_echo_bridge with a simple uart_tx model that
// accepts a byte when SEND and READY are both high, then stays busy.
module tb_uart_echo_bridge;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 5;
    localparam int BUSY       = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              tx_ready;
    logic              tx_send;
    logic [DATA_W-1:0] tx_data;
    logic              echo_en;
    logic              clr_ovr;
    logic [DATA_W-1:0] last_byte;
    logic              overrun;
    logic [CNT_W-1:0]  count;

    int   errors = 0;
    int   checks = 0;
    int   peak;
    logic seen_send;
    logic model_en;
    int   busy;
    logic [DATA_W-1:0] sent_q [$];

    uart_echo_bridge #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .LAST_RESET (8'hFF)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .RX_DONE   (rx_done),
        .RX_DATA   (rx_data),
        .TX_READY  (tx_ready),
        .TX_SEND   (tx_send),
        .TX_DATA   (tx_data),
        .ECHO_EN   (echo_en),
        .CLR_OVR   (clr_ovr),
        .LAST_BYTE (last_byte),
        .OVERRUN   (overrun),
        .COUNT     (count)
    );

    always #5 clk = ~clk;

    // uart_tx model, updated on the falling edge so the DUT sees stable inputs.
    initial begin
        tx_ready = 1'b1;
        busy     = 0;
        model_en = 1'b1;
        forever begin
            @(negedge clk);
            if (model_en) begin
                if (busy > 0) begin
                    busy = busy - 1;
                    if (busy == 0) tx_ready = 1'b1;
                end else if (tx_send && tx_ready) begin
                    sent_q.push_back(tx_data);
                    tx_ready = 1'b0;
                    busy     = BUSY;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(count) > peak) peak = int'(count);
        if (tx_send) seen_send = 1'b1;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (!(count == 0 && !tx_send && tx_ready && busy == 0) && n < limit) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: count=%0d still busy after %0d cycles", count, limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", tx_send); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", tx_data); end
        checks++; if (last_byte !== 8'hFF) begin errors++; $display("FAIL reset_last: got %h expected ff", last_byte); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    endtask

    task automatic test_single();
        sent_q.delete();
        echo_en = 1'b1;
        strobe(8'hA5);
        checks++; if (last_byte !== 8'hA5) begin errors++; $display("FAIL single_last: got %h expected a5", last_byte); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", count); end
        checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL single_send_early: got %b expected 0", tx_send); end
        tick();
        checks++; if (tx_send !== 1'b1) begin errors++; $display("FAIL single_send_rise: got %b expected 1", tx_send); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", tx_data); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d expected 0", count); end
        tick();
        checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL single_send_fall: got %b expected 0", tx_send); end
        rx_data = 8'h3E;
        tick();
        checks++; if (last_byte !== 8'hA5) begin errors++; $display("FAIL single_ignore_data: got %h expected a5", last_byte); end
        wait_drain(200);
        checks++;
        if (sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin
            errors++; $display("FAIL single_sent: got %0d bytes first %h expected 1 byte a5", sent_q.size(), sent_q[0]);
        end
    endtask

    task automatic test_three();
        sent_q.delete();
        peak = 0;
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        wait_drain(300);
        checks++;
        if (sent_q.size() != 3 || sent_q[0] !== 8'h01 || sent_q[1] !== 8'h02 || sent_q[2] !== 8'h03) begin
            errors++; $display("FAIL three_order: got %0d bytes %h %h %h expected 01 02 03",
                               sent_q.size(), sent_q[0], sent_q[1], sent_q[2]);
        end
        checks++; if (peak < 2 || peak > 3) begin errors++; $display("FAIL three_peak: got %0d expected 2..3", peak); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL three_count: got %0d expected 0", count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL three_ovr: got %b expected 0", overrun); end
    endtask

    task automatic test_fill_overrun();
        int bad;
        sent_q.delete();
        echo_en   = 1'b0;
        seen_send = 1'b0;
        for (int i = 0; i < 17; i++) strobe(8'h10 + 8'(i));
        tick();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", count); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL fill_ovr: got %b expected 1", overrun); end
        checks++; if (last_byte !== 8'h20) begin errors++; $display("FAIL fill_last: got %h expected 20", last_byte); end
        checks++; if (seen_send !== 1'b0) begin errors++; $display("FAIL fill_no_send: got %b expected 0", seen_send); end
        echo_en = 1'b1;
        wait_drain(1000);
        bad = 0;
        for (int i = 0; i < sent_q.size(); i++) if (sent_q[i] !== 8'h10 + 8'(i)) bad++;
        checks++;
        if (sent_q.size() != 16 || bad != 0) begin
            errors++; $display("FAIL fill_drain: got %0d bytes (%0d wrong) expected 16 bytes 10..1f", sent_q.size(), bad);
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_full_pop_push();
        sent_q.delete();
        echo_en = 1'b0;
        for (int i = 0; i < 16; i++) strobe(8'h40 + 8'(i));
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fpp_fill: got %0d expected 16", count); end
        echo_en = 1'b1;
        strobe(8'h77);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d expected 16", count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fpp_ovr: got %b expected 0", overrun); end
        checks++; if (tx_send !== 1'b1 || tx_data !== 8'h40) begin
            errors++; $display("FAIL fpp_first: got send=%b data=%h expected 1 40", tx_send, tx_data);
        end
        wait_drain(1000);
        checks++;
        if (sent_q.size() != 17 || sent_q[16] !== 8'h77) begin
            errors++; $display("FAIL fpp_last: got %0d bytes last %h expected 17 bytes last 77", sent_q.size(), sent_q[sent_q.size()-1]);
        end
    endtask

    task automatic test_clr_coincident();
        sent_q.delete();
        echo_en = 1'b0;
        for (int i = 0; i < 16; i++) strobe(8'h60 + 8'(i));
        clr_ovr = 1'b1;
        strobe(8'h99);
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %b expected 1", overrun); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL clr_count: got %0d expected 16", count); end
        checks++; if (last_byte !== 8'h99) begin errors++; $display("FAIL clr_last: got %h expected 99", last_byte); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_pulse: got %b expected 0", overrun); end
        echo_en = 1'b1;
        wait_drain(1000);
        checks++;
        if (sent_q.size() != 16 || sent_q[15] !== 8'h6F) begin
            errors++; $display("FAIL clr_drain: got %0d bytes last %h expected 16 bytes last 6f", sent_q.size(), sent_q[sent_q.size()-1]);
        end
    endtask

    task automatic test_reset_in_send();
        model_en = 1'b0;
        echo_en  = 1'b1;
        strobe(8'h5A);
        tick();
        checks++; if (tx_send !== 1'b1 || tx_data !== 8'h5A) begin
            errors++; $display("FAIL rst_pre: got send=%b data=%h expected 1 5a", tx_send, tx_data);
        end
        tick(); tick(); tick();
        checks++; if (tx_send !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b expected 1", tx_send); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL rst_send: got %b expected 0", tx_send); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (last_byte !== 8'hFF) begin errors++; $display("FAIL rst_last: got %h expected ff", last_byte); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", tx_data); end
        seen_send = 1'b0;
        tick(); tick();
        checks++; if (seen_send !== 1'b0) begin errors++; $display("FAIL rst_idle: got send=%b expected 0", seen_send); end
        sent_q.delete();
        model_en = 1'b1;
        strobe(8'h3C);
        wait_drain(200);
        checks++;
        if (sent_q.size() != 1 || sent_q[0] !== 8'h3C) begin
            errors++; $display("FAIL rst_after: got %0d bytes first %h expected 1 byte 3c", sent_q.size(), sent_q[0]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        rx_done   = 1'b0;
        rx_data   = '0;
        echo_en   = 1'b1;
        clr_ovr   = 1'b0;
        peak      = 0;
        seen_send = 1'b0;
        test_reset();
        test_single();
        test_three();
        test_fill_overrun();
        test_full_pop_push();
        test_clr_coincident();
        test_reset_in_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
